// File: rtl/stream_accumulator_pkg.sv
// Shared types and default sizing for the stream accumulator slice.
package stream_accumulator_pkg;

  localparam int unsigned DEF_WIDTH   = 24;
  localparam int unsigned DEF_COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/generic_adder.sv
// Generic ripple-carry adder; c exposes the carry out of every bit position.
module generic_adder #(
  parameter int unsigned width = 24
) (
  input  logic [width-1:0] ain,
  input  logic [width-1:0] bin,
  input  logic             cin,
  output logic [width-1:0] sum,
  output logic             carry,
  output logic [width-1:0] c
);

  logic [width:0] chain;

  assign chain[0] = cin;

  for (genvar i = 0; i < width; i++) begin : g_bit
    assign sum[i]       = ain[i] ^ bin[i] ^ chain[i];
    assign chain[i + 1] = (ain[i] & bin[i]) | (chain[i] & (ain[i] ^ bin[i]));
  end

  assign c     = chain[width:1];
  assign carry = chain[width];

endmodule

// File: rtl/stream_accumulator.sv
// Sums a burst of unsigned operands from a valid/ready stream and presents the
// modulo-2^WIDTH total with a sticky carry-out flag on a valid/ready result port.
module stream_accumulator
  import stream_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_ovf,
  output logic               busy
);

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [COUNT_W-1:0] remaining;
  logic               ovf;
  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;

  generic_adder #(
    .width(WIDTH)
  ) u_adder (
    .ain  (acc),
    .bin  (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .carry(add_carry),
    .c    ()
  );

  // Handshake outputs are registered alongside the state so neither ready nor
  // valid has a combinational path from the opposite side's handshake input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b1;
            if (num_samples != '0) begin
              remaining <= num_samples;
              in_ready  <= 1'b1;
              state     <= ACCUM;
            end else begin
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc       <= add_sum;
            ovf       <= ovf | add_carry;
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // acc and ovf already hold their value until the next accepted start.
  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_stream_accumulator.sv
// Directed self-checking bench for stream_accumulator.
module tb_stream_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int n_tests;
  int n_fail;

  stream_accumulator #(
    .WIDTH  (24),
    .COUNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_samples(num_samples),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_ovf    (out_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start       = 1'b1;
    num_samples = n;
    step();
    start       = 1'b0;
    num_samples = 8'hxx;
  endtask

  task automatic send_beat(input logic [23:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [23:0] sum, input logic ovf);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"}, {8'd0, out_sum}, {8'd0, sum});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, ovf});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = 8'd0;
    in_valid    = 1'b0;
    in_data     = 24'd0;
    out_ready   = 1'b0;

    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {8'd0, out_sum}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic burst of three
    do_start(8'd3);
    check("basic_in_ready", {31'd0, in_ready}, 32'd1);
    check("basic_busy", {31'd0, busy}, 32'd1);
    send_beat(24'h000005);
    send_beat(24'h000010);
    check("basic_early_valid", {31'd0, out_valid}, 32'd0);
    send_beat(24'h000020);
    check("basic_in_ready_off", {31'd0, in_ready}, 32'd0);
    check_result("basic", 24'h000035, 1'b0);
    check("basic_sum_held", {8'd0, out_sum}, 32'h35);

    // Overflow then clear on next start
    do_start(8'd2);
    check("ovf_start_sum_clr", {8'd0, out_sum}, 32'd0);
    send_beat(24'hFFFFFF);
    send_beat(24'h000002);
    check_result("ovf", 24'h000001, 1'b1);
    do_start(8'd1);
    check("ovf_start_ovf_clr", {31'd0, out_ovf}, 32'd0);
    send_beat(24'h000007);
    check_result("ovf_next", 24'h000007, 1'b0);

    // Input backpressure (valid toggling) and output backpressure
    do_start(8'd4);
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (i % 2 == 0) ? 24'((i / 2 + 1) * 256) : 24'hFFFFFF;
      step();
      if (i == 5) check("bp_three_beats", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1;
    in_data  = 24'hFFFFFF;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_sum", {8'd0, out_sum}, 32'h000A00);
      check("bp_hold_ovf", {31'd0, out_ovf}, 32'd0);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    check_result("bp", 24'h000A00, 1'b0);

    // Zero-length burst
    do_start(8'd0);
    check("zero_in_ready", {31'd0, in_ready}, 32'd0);
    check_result("zero", 24'h000000, 1'b0);

    // Start during ACCUM is ignored
    do_start(8'd3);
    send_beat(24'h000011);
    start       = 1'b1;
    num_samples = 8'd7;
    step();
    start       = 1'b0;
    send_beat(24'h000022);
    send_beat(24'h000033);
    check_result("ign_start", 24'h000066, 1'b0);

    // Asynchronous reset mid-burst
    do_start(8'd5);
    send_beat(24'h000001);
    send_beat(24'h000002);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_sum", {8'd0, out_sum}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    do_start(8'd1);
    send_beat(24'h000009);
    check_result("post_rst", 24'h000009, 1'b0);

    // Maximum burst length
    do_start(8'd255);
    for (int i = 0; i < 254; i++) send_beat(24'h010000);
    check("max_early_valid", {31'd0, out_valid}, 32'd0);
    send_beat(24'h010000);
    check_result("max_a", 24'hFF0000, 1'b0);
    do_start(8'd255);
    for (int i = 0; i < 255; i++) send_beat(24'h020000);
    check_result("max_b", 24'hFE0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_accumulator.md
Name: stream_accumulator

Overview:
- Sequential consumer and driver of the team's ripple-carry adder.
- Accepts a burst of N unsigned WIDTH-bit operands over a valid/ready stream and sums them modulo 2^WIDTH, one operand per cycle.
- Records a sticky overflow flag from the adder carry-out.
- Presents the final sum on a valid/ready output port; sits between an operand source (FIFO/DMA) and any result consumer.

Parameters:
WIDTH, 24, operand and accumulator width in bits
COUNT_W, 8, width of the burst-length field; max burst = 2^COUNT_W - 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a burst; sampled only in IDLE
num_samples  input  COUNT_W  burst length, captured on accepted start
in_valid  input  1  operand valid
in_ready  output  1  accumulator can accept an operand this cycle
in_data  input  WIDTH  unsigned operand
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  accumulated sum modulo 2^WIDTH
out_ovf  output  1  sticky: any addition in the burst produced a carry-out
busy  output  1  high in ACCUM or HOLD

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; acc=0, remaining=0, ovf=0. Reset values of outputs: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with num_samples>0: acc<=0, ovf<=0, remaining<=num_samples, go to ACCUM.
  - start=1 with num_samples==0: acc<=0, ovf<=0, go directly to HOLD (empty burst returns sum 0, ovf 0).
- ACCUM:
  - in_ready=1 for every cycle of the state.
  - Beat accepted when in_valid & in_ready: acc<=acc+in_data (WIDTH-bit sum; carry discarded from acc), ovf<=ovf|carry_out, remaining<=remaining-1.
  - Accepted beat with remaining==1: go to HOLD.
  - in_valid low: hold all state; no timeout.
- HOLD:
  - out_valid=1, out_sum=acc, out_ovf=ovf; outputs stable while out_ready=0.
  - out_ready=1: go to IDLE next cycle.
- Latency: out_valid asserts on the cycle after the last operand is accepted.
- Throughput: one operand per cycle; minimum turnaround is one IDLE cycle between bursts.
- start is ignored outside IDLE; num_samples is only sampled with an accepted start.
- out_sum and out_ovf hold their last values after leaving HOLD until the next accepted start clears them (acc=0, ovf=0 on start).
- Addition semantics: unsigned, modulo 2^WIDTH. Carry-in to the adder is tied to 0. ovf captures any wrap, including wraps that are later offset by further operands.
- Reset asserted mid-burst: immediate abort to IDLE; no out_valid is produced for the aborted burst; partial sum is lost.
- Outputs are registered or decoded from registered state only; there is no combinational path from in_valid to in_ready or from out_ready to out_valid.

Decomposition:
- Shared package holds the state enum (IDLE, ACCUM, HOLD) and the default WIDTH/COUNT_W constants.
- One sub-module: the combination path instantiates the existing generic_adder with width=WIDTH.
  - ain=acc, bin=in_data, cin=0.
  - carry drives the ovf update.
  - The internal carry-chain output c is left unconnected.
- FSM, counter and registers live in stream_accumulator itself.

Test Plan:
- Basic burst: start with num_samples=3, operands 0x000005, 0x000010, 0x000020, all with in_valid held high -> out_valid one cycle after the third beat, out_sum=0x000035, out_ovf=0.
- Overflow: num_samples=2, operands 0xFFFFFF and 0x000002 -> out_sum=0x000001, out_ovf=1. A following burst of 1 operand 0x000007 -> out_sum=0x000007, out_ovf=0 (ovf cleared on start).
- Backpressure both sides: num_samples=4 with in_valid toggling 1,0,1,0,...; then out_ready held 0 for 5 cycles -> exactly 4 beats accepted; out_sum/out_ovf stable and out_valid=1 for all 5 cycles; IDLE the cycle after out_ready=1.
- Zero-length and ignored start: start with num_samples=0 -> out_valid the next cycle with out_sum=0. A start pulse asserted during ACCUM -> no effect on remaining or acc.
- Reset mid-burst: assert rst asynchronously after 2 of 5 operands -> in_ready, out_valid and busy drop to 0 immediately. Then a new burst of 1 operand 0x000009 -> out_sum=0x000009.
- Max burst: num_samples=255, each operand 0x010000 -> out_sum=0xFF0000, out_ovf=0. The same burst with each operand 0x020000 -> out_ovf=1.
